ir_power_ctrl: RTL and testbench
================================

Name: ir_power_ctrl

Overview:
Parametrised successor to the single-bit IR standby LED controller. It decodes validated IR command bytes into three things: a global power state, N_CH per-channel enable bits, and a status LED. The LED carries an acknowledge blink, repeat-code holdoff and an idle auto-standby timeout. It sits after the IR demodulator/decoder and drives the board status LED and downstream enables.

Parameters:
CMD_W, 8, width of ir_cmd
N_CH, 4, number of channel enable outputs (1..16)
CMD_POWER, 8'h80, power toggle command code
CMD_CH_BASE, 8'h10, channel i toggle code = CMD_CH_BASE + i, i in 0..N_CH-1
HOLDOFF_CYC, 1000000, cycles after an accepted command during which an identical command is ignored
BLINK_CYC, 5000000, LED acknowledge blink length in cycles
IDLE_CYC, 0, cycles of no accepted command while ON before auto-standby; 0 disables timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ir_cmd  in  CMD_W  decoded command, qualified by ir_valid
ir_valid  in  1  one-cycle strobe, command present
led  out  1  1 = standby (lit), 0 = on (dark); inverted during blink
power_on  out  1  1 when in ON state
ch_en  out  N_CH  per-channel enable bits
cmd_ack  out  1  one-cycle pulse per accepted command
timeout_evt  out  1  one-cycle pulse on idle auto-standby

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=STANDBY; led=1, power_on=0, ch_en=0, cmd_ack=0, timeout_evt=0.
  - All counters=0; last-command register=0, last-command-valid=0.
- All outputs are registered. A command sampled with ir_valid at edge k is reflected in outputs after edge k (1-cycle latency).
- Recognised commands: CMD_POWER, or CMD_CH_BASE+i with i<N_CH. Any other code is ignored entirely: no ack, no counter effect.
- Holdoff:
  - A recognised command equal to the last accepted command, arriving while holdoff_cnt>0, is ignored.
  - A different recognised command is accepted regardless of holdoff.
  - On acceptance: holdoff_cnt loads HOLDOFF_CYC-1, last-command register updated. holdoff_cnt decrements to 0 and saturates there.
- States:
  - STANDBY: accepted CMD_POWER -> ON. Channel commands are ignored (not accepted, no ack).
  - ON: accepted CMD_POWER -> STANDBY and ch_en cleared. Accepted channel i toggles ch_en[i] only.
  - Encoding for unused states: return to STANDBY.
- Idle timeout (IDLE_CYC>0):
  - idle_cnt resets to 0 on every accepted command and on entry to ON; increments while ON.
  - When idle_cnt reaches IDLE_CYC-1: go to STANDBY, clear ch_en, pulse timeout_evt, no cmd_ack.
  - If an accepted command arrives in that same cycle, the command wins and the timeout does not fire.
- cmd_ack pulses for 1 cycle per accepted command.
- Blink:
  - Each accepted command loads blink_cnt with BLINK_CYC; it decrements to 0.
  - While blink_cnt>0, led = inverted base level; base level = (state==STANDBY).
  - A new accept during a blink reloads the counter. Timeout does not blink.
- Counter widths are $clog2(param+1). Arithmetic is saturating; no wrap.
- ir_valid for more than 1 cycle with the same code counts as repeats and is subject to holdoff.

Test Plan (bench params: HOLDOFF_CYC=8, BLINK_CYC=4, IDLE_CYC=32, N_CH=4):
- Reset then idle 10 cycles -> led=1, power_on=0, ch_en=0, no pulses.
- ir_cmd=8'h1F valid 1 cycle, then 8'h80 -> 8'h1F produces no ack. After 8'h80: power_on=1, cmd_ack one pulse, led=1 for 4 cycles then 0.
- In ON, send 8'h12 then 8'h12 again 3 cycles later -> ch_en=4'b0100 and only one ack. Send 8'h12 again 10 cycles after first -> ch_en=4'b0000.
- In STANDBY, send 8'h11 -> ch_en stays 0, no ack. Go ON, set ch_en=4'b0011, then 8'h80 after holdoff -> power_on=0, ch_en=0, led=1 with blink to 0 for 4 cycles.
- In ON, no commands for 32 cycles -> timeout_evt single pulse, power_on=0, ch_en=0, led=1 with no blink. Repeat with 8'h10 arriving on the expiry cycle -> stays ON, ch_en[0] toggles, no timeout_evt.
- Assert rst_n low mid-blink in ON with ch_en=4'b1111 -> all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ir_power_ctrl.sv
// IR power/channel controller: decodes validated IR command bytes into a
// global power state, per-channel enables and a status LED with an
// acknowledge blink, repeat-code holdoff and optional idle auto-standby.
module ir_power_ctrl #(
    parameter int               CMD_W       = 8,
    parameter int               N_CH        = 4,
    parameter logic [CMD_W-1:0] CMD_POWER   = 8'h80,
    parameter logic [CMD_W-1:0] CMD_CH_BASE = 8'h10,
    parameter int               HOLDOFF_CYC = 1000000,
    parameter int               BLINK_CYC   = 5000000,
    parameter int               IDLE_CYC    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] ir_cmd,
    input  logic             ir_valid,
    output logic             led,
    output logic             power_on,
    output logic [N_CH-1:0]  ch_en,
    output logic             cmd_ack,
    output logic             timeout_evt
);

    // Counter widths; a zero-length parameter still gets a 1-bit counter.
    localparam int HOLD_W  = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam int BLINK_W = (BLINK_CYC > 0)   ? $clog2(BLINK_CYC + 1)   : 1;
    localparam int IDLE_W  = (IDLE_CYC > 0)    ? $clog2(IDLE_CYC + 1)    : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = (HOLDOFF_CYC > 0) ? HOLD_W'(HOLDOFF_CYC - 1) : '0;
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYC);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = (IDLE_CYC > 0) ? IDLE_W'(IDLE_CYC - 1) : '0;
    localparam bit                 IDLE_EN    = (IDLE_CYC > 0);
    localparam logic [CMD_W:0]     CH_LIMIT   = (CMD_W + 1)'(N_CH);

    localparam logic [1:0] ST_STANDBY = 2'b00;
    localparam logic [1:0] ST_ON      = 2'b01;

    logic [1:0]         r_state;
    logic [N_CH-1:0]    r_ch_en;
    logic               r_led;
    logic               r_power_on;
    logic               r_cmd_ack;
    logic               r_timeout_evt;
    logic [HOLD_W-1:0]  r_holdoff_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic [CMD_W-1:0]   r_last_cmd;
    logic               r_last_vld;

    logic [CMD_W:0]     w_ch_off;
    logic               w_is_power;
    logic               w_is_ch;
    logic               w_repeat;
    logic               w_legal;
    logic               w_accept;
    logic               w_idle_hit;
    logic               w_timeout;
    logic [1:0]         w_state_nxt;
    logic [N_CH-1:0]    w_ch_nxt;
    logic [HOLD_W-1:0]  w_holdoff_nxt;
    logic [BLINK_W-1:0] w_blink_nxt;
    logic [IDLE_W-1:0]  w_idle_nxt;

    // Extra MSB on the offset catches codes below the channel base.
    assign w_ch_off   = {1'b0, ir_cmd} - {1'b0, CMD_CH_BASE};
    assign w_is_power = (ir_cmd == CMD_POWER);
    assign w_is_ch    = ~w_ch_off[CMD_W] && (w_ch_off < CH_LIMIT);
    assign w_repeat   = r_last_vld && (ir_cmd == r_last_cmd) && (r_holdoff_cnt != '0);
    assign w_legal    = (r_state == ST_STANDBY) || (r_state == ST_ON);
    // Channel codes only count as commands once powered on; power code wins any overlap.
    assign w_accept   = ir_valid && !w_repeat && w_legal &&
                        (w_is_power || (w_is_ch && (r_state == ST_ON)));
    assign w_idle_hit = IDLE_EN && (r_state == ST_ON) && (r_idle_cnt == IDLE_LAST);

    // Next power state and channel enables; an accepted command pre-empts the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch_en;
        w_timeout   = 1'b0;
        case (r_state)
            ST_STANDBY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (w_accept) begin
                    if (w_is_power) begin
                        w_state_nxt = ST_STANDBY;
                        w_ch_nxt    = '0;
                    end else begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (w_ch_off == (CMD_W + 1)'(i)) begin
                                w_ch_nxt[i] = ~r_ch_en[i];
                            end
                        end
                    end
                end else if (w_idle_hit) begin
                    w_state_nxt = ST_STANDBY;
                    w_ch_nxt    = '0;
                    w_timeout   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_STANDBY;
                w_ch_nxt    = '0;
            end
        endcase
    end

    // Saturating counters: holdoff and blink reload on accept, idle runs only while ON.
    always_comb begin
        w_holdoff_nxt = (r_holdoff_cnt != '0) ? r_holdoff_cnt - 1'b1 : '0;
        w_blink_nxt   = (r_blink_cnt != '0)   ? r_blink_cnt - 1'b1   : '0;
        w_idle_nxt    = '0;
        if (w_accept) begin
            w_holdoff_nxt = HOLD_LOAD;
            w_blink_nxt   = BLINK_LOAD;
        end
        if (IDLE_EN && !w_accept && (w_state_nxt == ST_ON)) begin
            w_idle_nxt = (r_idle_cnt != '1) ? r_idle_cnt + 1'b1 : r_idle_cnt;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_STANDBY;
            r_ch_en       <= '0;
            r_led         <= 1'b1;
            r_power_on    <= 1'b0;
            r_cmd_ack     <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_holdoff_cnt <= '0;
            r_blink_cnt   <= '0;
            r_idle_cnt    <= '0;
            r_last_cmd    <= '0;
            r_last_vld    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ch_en       <= w_ch_nxt;
            r_led         <= (w_state_nxt == ST_STANDBY) ^ (w_blink_nxt != '0);
            r_power_on    <= (w_state_nxt == ST_ON);
            r_cmd_ack     <= w_accept;
            r_timeout_evt <= w_timeout;
            r_holdoff_cnt <= w_holdoff_nxt;
            r_blink_cnt   <= w_blink_nxt;
            r_idle_cnt    <= w_idle_nxt;
            if (w_accept) begin
                r_last_cmd <= ir_cmd;
                r_last_vld <= 1'b1;
            end
        end
    end

    assign led         = r_led;
    assign power_on    = r_power_on;
    assign ch_en       = r_ch_en;
    assign cmd_ack     = r_cmd_ack;
    assign timeout_evt = r_timeout_evt;

endmodule

// File: tb/tb_ir_power_ctrl.sv
// Bench for ir_power_ctrl: table of cycle vectors plus hand-written
// timeout and asynchronous-reset sequences, checked through a scoreboard.
module tb_ir_power_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] ir_cmd;
    logic       ir_valid;
    logic       led;
    logic       power_on;
    logic [3:0] ch_en;
    logic       cmd_ack;
    logic       timeout_evt;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit         v;
        logic [7:0] cmd;
        int         rep;
        bit         led;
        bit         pwr;
        logic [3:0] ch;
        bit         ack;
        bit         to;
    } vec_t;

    typedef struct {
        string      name;
        bit         led;
        bit         pwr;
        logic [3:0] ch;
        bit         ack;
        bit         to;
    } exp_t;

    localparam int NV = 26;
    vec_t tbl [NV];
    exp_t sb [$];

    ir_power_ctrl #(
        .CMD_W      (8),
        .N_CH       (4),
        .CMD_POWER  (8'h80),
        .CMD_CH_BASE(8'h10),
        .HOLDOFF_CYC(8),
        .BLINK_CYC  (4),
        .IDLE_CYC   (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_cmd     (ir_cmd),
        .ir_valid   (ir_valid),
        .led        (led),
        .power_on   (power_on),
        .ch_en      (ch_en),
        .cmd_ack    (cmd_ack),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input bit e_led, input bit e_pwr,
                       input logic [3:0] e_ch, input bit e_ack, input bit e_to);
        n_total++;
        if ({led, power_on, ch_en, cmd_ack, timeout_evt} !== {e_led, e_pwr, e_ch, e_ack, e_to}) begin
            $display("FAIL %s: got led=%b pwr=%b ch=%b ack=%b to=%b, expected led=%b pwr=%b ch=%b ack=%b to=%b",
                     name, led, power_on, ch_en, cmd_ack, timeout_evt,
                     e_led, e_pwr, e_ch, e_ack, e_to);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then check after the edge.
    task automatic step(input string name, input bit v, input logic [7:0] c,
                        input bit e_led, input bit e_pwr, input logic [3:0] e_ch,
                        input bit e_ack, input bit e_to);
        exp_t e;
        @(negedge clk);
        ir_valid = v;
        ir_cmd   = c;
        e = '{name, e_led, e_pwr, e_ch, e_ack, e_to};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp(e.name, e.led, e.pwr, e.ch, e.ack, e.to);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            '{1'b0, 8'h00, 10, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0},  // idle after reset
            '{1'b1, 8'h1F,  1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0},  // unknown code ignored
            '{1'b1, 8'h80,  1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0},  // power on, blink starts
            '{1'b0, 8'h00,  3, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0},
            '{1'b0, 8'h00,  1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0},  // blink over, ON is dark
            '{1'b1, 8'h12,  1, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0},  // channel 2 on
            '{1'b0, 8'h00,  2, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0},
            '{1'b1, 8'h12,  1, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0},  // repeat inside holdoff
            '{1'b0, 8'h00,  6, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0},
            '{1'b1, 8'h12,  1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0},  // repeat after holdoff toggles
            '{1'b0, 8'h00,  3, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0},
            '{1'b0, 8'h00,  1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0},
            '{1'b1, 8'h14,  1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0},  // just past last channel
            '{1'b1, 8'h80,  1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0},  // power off, blink dark
            '{1'b0, 8'h00,  3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0},
            '{1'b0, 8'h00,  1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0},
            '{1'b1, 8'h11,  1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0},  // channel in standby ignored
            '{1'b0, 8'h00,  3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0},
            '{1'b1, 8'h80,  1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0},
            '{1'b1, 8'h10,  1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0},
            '{1'b1, 8'h11,  1, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0},
            '{1'b0, 8'h00,  3, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0},
            '{1'b0, 8'h00,  6, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0},
            '{1'b1, 8'h80,  1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0},  // power off clears channels
            '{1'b0, 8'h00,  3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0},
            '{1'b0, 8'h00,  1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}
        };

        ir_valid = 1'b0;
        ir_cmd   = 8'h00;
        #2 rst_n = 1'b0;
        #1 cmp("reset_entry", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                step($sformatf("vec%0d.%0d", i, r), tbl[i].v, tbl[i].cmd,
                     tbl[i].led, tbl[i].pwr, tbl[i].ch, tbl[i].ack, tbl[i].to);
            end
        end

        // Idle timeout: 32 cycles with no command while ON; no blink on expiry.
        for (int j = 0; j < 4; j++)
            step($sformatf("to_pre%0d", j), 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step("to_on", 1'b1, 8'h80, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
        for (int j = 1; j <= 32; j++)
            step($sformatf("to_idle%0d", j), 1'b0, 8'h00, (j <= 3) || (j == 32),
                 (j < 32), 4'h0, 1'b0, (j == 32));
        step("to_after", 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

        // Command on the expiry cycle wins over the timeout.
        step("race_on", 1'b1, 8'h80, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
        for (int j = 1; j <= 31; j++)
            step($sformatf("race_idle%0d", j), 1'b0, 8'h00, (j <= 3), 1'b1, 4'h0, 1'b0, 1'b0);
        step("race_cmd", 1'b1, 8'h10, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
        for (int j = 1; j <= 4; j++)
            step($sformatf("race_post%0d", j), 1'b0, 8'h00, (j <= 3), 1'b1, 4'h1, 1'b0, 1'b0);

        // Asynchronous reset mid-blink with every channel enabled.
        step("ar_ch1", 1'b1, 8'h11, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0);
        step("ar_ch2", 1'b1, 8'h12, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
        step("ar_ch3", 1'b1, 8'h13, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
        #2;
        ir_valid = 1'b0;
        rst_n    = 1'b0;
        #1 cmp("async_reset", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step("post_rst_ch",   1'b1, 8'h13, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step("post_rst_pwr",  1'b1, 8'h80, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
        step("post_rst_hold", 1'b1, 8'h80, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
